// File: rtl/hdmi_line_fetch_ctrl.sv
// Line-credit scheduler feeding the HDMI line FIFO: admits one fixed-length line per
// display-side request, padding short source lines and dropping the tail of long ones.
module hdmi_line_fetch_ctrl #(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 24,
  parameter int unsigned H_ACTIVE             = 1280,
  parameter int unsigned V_ACTIVE             = 720,
  parameter int unsigned MAX_CREDITS          = 2
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 LINE_REQ,
  input  logic                                 ERR_CLR,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic                                 S_AXIS_TVALID,
  input  logic                                 S_AXIS_TLAST,
  output logic                                 S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic                                 M_AXIS_TVALID,
  output logic                                 M_AXIS_TLAST,
  output logic                                 M_AXIS_TUSER,
  input  logic                                 M_AXIS_TREADY,
  output logic [$clog2(V_ACTIVE)-1:0]          LINE_CNT,
  output logic [$clog2(MAX_CREDITS+1)-1:0]     CREDITS,
  output logic                                 ERR_EARLY,
  output logic                                 ERR_LATE,
  output logic                                 ERR_OVF
);

  localparam int unsigned BeatW = $clog2(H_ACTIVE);
  localparam int unsigned LineW = $clog2(V_ACTIVE);
  localparam int unsigned CredW = $clog2(MAX_CREDITS + 1);

  localparam logic [BeatW-1:0] BeatLast = BeatW'(H_ACTIVE - 1);
  localparam logic [LineW-1:0] LineLast = LineW'(V_ACTIVE - 1);
  localparam logic [CredW-1:0] CredMax  = CredW'(MAX_CREDITS);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StPad,
    StDrop
  } state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [LineW-1:0]   line_cnt_q, line_cnt_d;
  logic [CredW-1:0]   credits_q, credits_d;
  logic               err_early_q, err_early_d;
  logic               err_late_q, err_late_d;
  logic               err_ovf_q, err_ovf_d;

  logic credit_take;
  logic credit_full;
  logic ovf_set;
  logic early_set;
  logic late_set;
  logic line_done;
  logic beat_last;
  logic in_line;

  // Credit bookkeeping
  always_comb begin
    credit_take = (state_q == StIdle) && (credits_q != '0);
    credit_full = (credits_q == CredMax);
    ovf_set     = 1'b0;
    credits_d   = credits_q;
    if (LINE_REQ && !credit_take) begin
      if (credit_full) begin
        ovf_set = 1'b1;
      end else begin
        credits_d = credits_q + CredW'(1);
      end
    end else if (!LINE_REQ && credit_take) begin
      credits_d = credits_q - CredW'(1);
    end
  end

  // Line FSM and data path
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    early_set     = 1'b0;
    late_set      = 1'b0;
    line_done     = 1'b0;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    beat_last     = (beat_q == BeatLast);

    case (state_q)
      StIdle: begin
        if (credit_take) begin
          state_d = StStream;
          beat_d  = '0;
        end
      end

      StStream: begin
        M_AXIS_TVALID = S_AXIS_TVALID;
        S_AXIS_TREADY = M_AXIS_TREADY;
        M_AXIS_TDATA  = S_AXIS_TDATA;
        if (S_AXIS_TVALID && M_AXIS_TREADY) begin
          if (beat_last) begin
            // The FIFO line is complete either way; a missing source TLAST means
            // the rest of the source line must be discarded.
            line_done = 1'b1;
            beat_d    = '0;
            if (S_AXIS_TLAST) begin
              state_d = StIdle;
            end else begin
              late_set = 1'b1;
              state_d  = StDrop;
            end
          end else begin
            beat_d = beat_q + BeatW'(1);
            if (S_AXIS_TLAST) begin
              early_set = 1'b1;
              state_d   = StPad;
            end
          end
        end
      end

      StPad: begin
        M_AXIS_TVALID = 1'b1;
        if (M_AXIS_TREADY) begin
          if (beat_last) begin
            line_done = 1'b1;
            beat_d    = '0;
            state_d   = StIdle;
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end

      StDrop: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && S_AXIS_TLAST) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (line_done) begin
      line_cnt_d = (line_cnt_q == LineLast) ? '0 : line_cnt_q + LineW'(1);
    end
  end

  // A flag raised in the same cycle as ERR_CLR stays set.
  always_comb begin
    err_early_d = early_set | (err_early_q & ~ERR_CLR);
    err_late_d  = late_set  | (err_late_q  & ~ERR_CLR);
    err_ovf_d   = ovf_set   | (err_ovf_q   & ~ERR_CLR);
  end

  always_comb begin
    in_line      = (state_q == StStream) || (state_q == StPad);
    M_AXIS_TLAST = in_line && (beat_q == BeatLast);
    M_AXIS_TUSER = in_line && (beat_q == '0) && (line_cnt_q == '0);
    LINE_CNT     = line_cnt_q;
    CREDITS      = credits_q;
    ERR_EARLY    = err_early_q;
    ERR_LATE     = err_late_q;
    ERR_OVF      = err_ovf_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      line_cnt_q  <= '0;
      credits_q   <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      line_cnt_q  <= line_cnt_d;
      credits_q   <= credits_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Directed bench for hdmi_line_fetch_ctrl with an 8-beat, 3-line frame and 2 credits.
module tb_hdmi_line_fetch_ctrl;

  localparam int DW = 24;
  localparam int H  = 8;
  localparam int V  = 3;
  localparam int MC = 2;

  logic          ACLK          = 1'b0;
  logic          ARESET        = 1'b1;
  logic          LINE_REQ      = 1'b0;
  logic          ERR_CLR       = 1'b0;
  logic [DW-1:0] S_AXIS_TDATA  = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TLAST  = 1'b0;
  logic          M_AXIS_TREADY = 1'b1;
  logic          S_AXIS_TREADY;
  logic [DW-1:0] M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TUSER;
  logic [1:0]    LINE_CNT;
  logic [1:0]    CREDITS;
  logic          ERR_EARLY;
  logic          ERR_LATE;
  logic          ERR_OVF;

  int n_vec = 0;
  int n_err = 0;
  bit bp_en = 1'b0;
  bit bp_chk = 1'b0;
  int bp_viol = 0;
  bit src_fire = 1'b0;

  logic [DW:0]   src_q[$];  // {tlast, data}
  logic [DW+1:0] out_q[$];  // {tuser, tlast, data}

  hdmi_line_fetch_ctrl #(
    .C_S_AXIS_TDATA_WIDTH(DW),
    .H_ACTIVE            (H),
    .V_ACTIVE            (V),
    .MAX_CREDITS         (MC)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .LINE_REQ     (LINE_REQ),
    .ERR_CLR      (ERR_CLR),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TUSER (M_AXIS_TUSER),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .LINE_CNT     (LINE_CNT),
    .CREDITS      (CREDITS),
    .ERR_EARLY    (ERR_EARLY),
    .ERR_LATE     (ERR_LATE),
    .ERR_OVF      (ERR_OVF)
  );

  always #5 ACLK = ~ACLK;

  // Source driver and FIFO-side monitor: sample mid-cycle, drive 1 after the edge.
  always begin
    @(negedge ACLK);
    if (!ARESET && M_AXIS_TVALID && M_AXIS_TREADY)
      out_q.push_back({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA});
    src_fire = !ARESET && S_AXIS_TVALID && S_AXIS_TREADY;
    if (bp_chk && !ARESET) begin
      if (S_AXIS_TREADY && !M_AXIS_TREADY) bp_viol++;
      if ((M_AXIS_TVALID && M_AXIS_TREADY) != src_fire) bp_viol++;
    end
    @(posedge ACLK);
    #1;
    if (src_fire && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0) begin
      S_AXIS_TVALID = 1'b1;
      {S_AXIS_TLAST, S_AXIS_TDATA} = src_q[0];
    end else begin
      S_AXIS_TVALID = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      S_AXIS_TDATA  = '0;
    end
    M_AXIS_TREADY = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic do_reset();
    ARESET   = 1'b1;
    LINE_REQ = 1'b0;
    ERR_CLR  = 1'b0;
    src_q.delete();
    tick();
    tick();
    ARESET = 1'b0;
    out_q.delete();
  endtask

  task automatic pulse_req();
    LINE_REQ = 1'b1;
    tick();
    LINE_REQ = 1'b0;
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 400 && out_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) tick();
    ARESET = 1'b0;
    n_vec++; if (CREDITS !== 2'd0) begin n_err++; $display("FAIL reset_credits got=%0d exp=0", CREDITS); end
    n_vec++; if (LINE_CNT !== 2'd0) begin n_err++; $display("FAIL reset_line_cnt got=%0d exp=0", LINE_CNT); end
    n_vec++; if ({S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER} !== 4'b0000) begin
      n_err++; $display("FAIL reset_handshake got=%b exp=0000",
                        {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER});
    end
    n_vec++; if ({ERR_EARLY, ERR_LATE, ERR_OVF} !== 3'b000) begin
      n_err++; $display("FAIL reset_errors got=%b exp=000", {ERR_EARLY, ERR_LATE, ERR_OVF});
    end
  endtask

  task automatic test_nominal();
    logic [DW+1:0] e;
    do_reset();
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < H; b++) src_q.push_back({b == H - 1, DW'(32'hA00 + l * 16 + b)});
    for (int l = 0; l < 4; l++) begin
      n_vec++; if (LINE_CNT !== 2'(l % V)) begin
        n_err++; $display("FAIL nominal_line_cnt%0d got=%0d exp=%0d", l, LINE_CNT, l % V);
      end
      pulse_req();
      repeat (12) tick();
    end
    wait_out(32);
    n_vec++; if (out_q.size() != 32) begin n_err++; $display("FAIL nominal_count got=%0d exp=32", out_q.size()); end
    n_vec++; if (LINE_CNT !== 2'd1) begin n_err++; $display("FAIL nominal_line_cnt_end got=%0d exp=1", LINE_CNT); end
    for (int i = 0; i < 32; i++) begin
      e = {i == 0 || i == 24, i % 8 == 7, DW'(32'hA00 + (i / 8) * 16 + i % 8)};
      n_vec++; if (out_q[i] !== e) begin n_err++; $display("FAIL nominal_beat%0d got=%0h exp=%0h", i, out_q[i], e); end
    end
    n_vec++; if ({ERR_EARLY, ERR_LATE, ERR_OVF} !== 3'b000) begin
      n_err++; $display("FAIL nominal_errors got=%b exp=000", {ERR_EARLY, ERR_LATE, ERR_OVF});
    end
  endtask

  task automatic test_backpressure();
    logic [DW+1:0] e;
    do_reset();
    bp_viol = 0;
    bp_en   = 1'b1;
    bp_chk  = 1'b1;
    for (int i = 0; i < 2 * H; i++) src_q.push_back({i % 8 == 7, DW'(32'hB00 + i)});
    LINE_REQ = 1'b1;
    tick();
    tick();
    LINE_REQ = 1'b0;
    wait_out(16);
    repeat (10) tick();
    bp_chk = 1'b0;
    bp_en  = 1'b0;
    n_vec++; if (out_q.size() != 16) begin n_err++; $display("FAIL bp_count got=%0d exp=16", out_q.size()); end
    n_vec++; if (bp_viol != 0) begin n_err++; $display("FAIL bp_ready_coupling got=%0d exp=0", bp_viol); end
    for (int i = 0; i < 16; i++) begin
      e = {i == 0, i % 8 == 7, DW'(32'hB00 + i)};
      n_vec++; if (out_q[i] !== e) begin n_err++; $display("FAIL bp_beat%0d got=%0h exp=%0h", i, out_q[i], e); end
    end
    n_vec++; if ({ERR_EARLY, ERR_LATE, ERR_OVF} !== 3'b000) begin
      n_err++; $display("FAIL bp_errors got=%b exp=000", {ERR_EARLY, ERR_LATE, ERR_OVF});
    end
  endtask

  task automatic test_short_line();
    logic [DW+1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) src_q.push_back({i == 4, DW'(i + 1)});
    pulse_req();
    wait_out(8);
    repeat (3) tick();
    n_vec++; if (out_q.size() != 8) begin n_err++; $display("FAIL short_count got=%0d exp=8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      e = {i == 0, i == 7, (i < 5) ? DW'(i + 1) : DW'(0)};
      n_vec++; if (out_q[i] !== e) begin n_err++; $display("FAIL short_beat%0d got=%0h exp=%0h", i, out_q[i], e); end
    end
    n_vec++; if ({ERR_EARLY, ERR_LATE} !== 2'b10) begin
      n_err++; $display("FAIL short_errors got=%b exp=10", {ERR_EARLY, ERR_LATE});
    end
    n_vec++; if (LINE_CNT !== 2'd1) begin n_err++; $display("FAIL short_line_cnt got=%0d exp=1", LINE_CNT); end
  endtask

  task automatic test_long_line();
    logic [DW+1:0] e;
    do_reset();
    for (int i = 0; i < 11; i++) src_q.push_back({i == 10, DW'(32'h10 + i)});
    for (int i = 0; i < 8; i++) src_q.push_back({i == 7, DW'(32'h20 + i)});
    pulse_req();
    wait_out(8);
    repeat (8) tick();
    n_vec++; if (src_q.size() != 8) begin n_err++; $display("FAIL long_dropped got=%0d exp=8 left", src_q.size()); end
    n_vec++; if ({ERR_EARLY, ERR_LATE} !== 2'b01) begin
      n_err++; $display("FAIL long_errors got=%b exp=01", {ERR_EARLY, ERR_LATE});
    end
    pulse_req();
    wait_out(16);
    repeat (3) tick();
    n_vec++; if (out_q.size() != 16) begin n_err++; $display("FAIL long_count got=%0d exp=16", out_q.size()); end
    for (int i = 0; i < 16; i++) begin
      e = {i == 0, i % 8 == 7, (i < 8) ? DW'(32'h10 + i) : DW'(32'h20 + i - 8)};
      n_vec++; if (out_q[i] !== e) begin n_err++; $display("FAIL long_beat%0d got=%0h exp=%0h", i, out_q[i], e); end
    end
    n_vec++; if (LINE_CNT !== 2'd2) begin n_err++; $display("FAIL long_line_cnt got=%0d exp=2", LINE_CNT); end
  endtask

  task automatic test_credits();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if ({M_AXIS_TVALID, S_AXIS_TREADY} !== 2'b00) begin
        n_err++; $display("FAIL cred_idle%0d got=%b exp=00", i, {M_AXIS_TVALID, S_AXIS_TREADY});
      end
    end
    pulse_req();
    n_vec++; if ({CREDITS, S_AXIS_TREADY} !== 3'b010) begin
      n_err++; $display("FAIL cred_grant got=%b exp=010", {CREDITS, S_AXIS_TREADY});
    end
    tick();
    n_vec++; if ({CREDITS, S_AXIS_TREADY, M_AXIS_TVALID} !== 4'b0010) begin
      n_err++; $display("FAIL cred_take got=%b exp=0010", {CREDITS, S_AXIS_TREADY, M_AXIS_TVALID});
    end
    LINE_REQ = 1'b1;
    tick();
    n_vec++; if (CREDITS !== 2'd1) begin n_err++; $display("FAIL cred_one got=%0d exp=1", CREDITS); end
    tick();
    tick();
    LINE_REQ = 1'b0;
    n_vec++; if ({CREDITS, ERR_OVF} !== 3'b101) begin
      n_err++; $display("FAIL cred_ovf got=%b exp=101", {CREDITS, ERR_OVF});
    end
    LINE_REQ = 1'b1;
    ERR_CLR  = 1'b1;
    tick();
    LINE_REQ = 1'b0;
    ERR_CLR  = 1'b0;
    n_vec++; if (ERR_OVF !== 1'b1) begin n_err++; $display("FAIL cred_set_wins got=%b exp=1", ERR_OVF); end
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    n_vec++; if ({CREDITS, ERR_OVF} !== 3'b100) begin
      n_err++; $display("FAIL cred_clr got=%b exp=100", {CREDITS, ERR_OVF});
    end
  endtask

  task automatic test_reset_mid_line();
    logic [DW+1:0] e;
    do_reset();
    for (int i = 0; i < 2 * H; i++) src_q.push_back({i % 8 == 7, DW'(32'h50 + i)});
    pulse_req();
    wait_out(8);
    repeat (3) tick();
    pulse_req();
    wait_out(11);
    pulse_req();
    n_vec++; if (CREDITS !== 2'd1) begin n_err++; $display("FAIL rst_pre_credits got=%0d exp=1", CREDITS); end
    ARESET = 1'b1;
    src_q.delete();
    tick();
    ARESET = 1'b0;
    n_vec++; if ({CREDITS, LINE_CNT} !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_counters got=%b exp=0000", {CREDITS, LINE_CNT});
    end
    n_vec++; if ({S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER} !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_outputs got=%b exp=0000",
                        {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER});
    end
    out_q.delete();
    for (int i = 0; i < H; i++) src_q.push_back({i == 7, DW'(32'h60 + i)});
    pulse_req();
    wait_out(8);
    repeat (3) tick();
    n_vec++; if (out_q.size() != 8) begin n_err++; $display("FAIL rst_next_count got=%0d exp=8", out_q.size()); end
    for (int i = 0; i < 8; i++) begin
      e = {i == 0, i == 7, DW'(32'h60 + i)};
      n_vec++; if (out_q[i] !== e) begin n_err++; $display("FAIL rst_next_beat%0d got=%0h exp=%0h", i, out_q[i], e); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_line();
    test_long_line();
    test_credits();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
